// File: rtl/esp_pkg.sv
// esp_pkg: constants and types shared across the ESP SPI datapath
package esp_pkg;
  localparam int ESP_MEM_ADDR_W = 14;
  localparam int ESP_BANKS = 2;
  localparam logic [7:0] ESP_CMD_MEM_RD = 8'h8F;
  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_e;
endpackage

// File: rtl/esp_rd_fifo.sv
// esp_rd_fifo: DEPTH x 8 prefetch FIFO with flush, async clear and combinational head
module esp_rd_fifo
  import esp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     spi_clk,
  input  logic                     clr_n,
  input  logic                     flush,
  input  logic                     wr,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic                     vld,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_wr, do_pop;
  assign vld = count != '0;
  assign do_wr = wr & ~flush;
  assign do_pop = pop & vld & ~flush;
  assign rd_data = vld ? mem[rp] : 8'h00;
  always_ff @(posedge spi_clk or negedge clr_n) begin
    if (!clr_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_pop);
    end
  end
  always_ff @(posedge spi_clk) begin
    if (do_wr) mem[wp] <= wr_data;
  end
endmodule

// File: rtl/esp_rd_prefetch.sv
// esp_rd_prefetch: sequential RAM-bank reader feeding a small FIFO for the ESP SPI slave
module esp_rd_prefetch
  import esp_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ESP_MEM_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              spi_clk,
  input  logic              rst_n,
  input  logic              i_spi_cs_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic              i_bank,
  input  logic              i_pop,
  output logic [7:0]        o_data,
  output logic              o_data_vld,
  output logic              o_ram_rd,
  output logic [ADDR_W:0]   o_ram_addr,
  input  logic [7:0]        i_ram_data,
  output logic              o_underrun,
  output logic [CNT_W-1:0]  o_byte_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] FULL = (CW+1)'(DEPTH);
  rd_state_e state, state_nxt;
  logic clr_n, bank, rd_q, pop_eff;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  assign clr_n = rst_n & ~i_spi_cs_n;
  assign pop_eff = i_pop & ~i_load;
  assign occ = {1'b0, count} + {{CW{1'b0}}, rd_q};
  assign o_ram_addr = {bank, rd_ptr};
  always_comb begin
    state_nxt = i_load ? RD_STREAM : state;
    o_ram_rd = (state == RD_STREAM) && (occ < FULL);
  end
  // rd_q marks a read whose data lands next edge; clearing it on load squashes that return
  always_ff @(posedge spi_clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= RD_IDLE;
      bank <= 1'b0;
      rd_ptr <= '0;
      rd_q <= 1'b0;
      o_underrun <= 1'b0;
      o_byte_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (i_load) begin
        bank <= i_bank;
        rd_ptr <= i_load_addr;
        rd_q <= 1'b0;
        o_byte_cnt <= '0;
      end else begin
        rd_q <= o_ram_rd;
        if (o_ram_rd) rd_ptr <= rd_ptr + 1'b1;
        if (pop_eff && ~&o_byte_cnt) o_byte_cnt <= o_byte_cnt + 1'b1;
        if (pop_eff && !o_data_vld) o_underrun <= 1'b1;
      end
    end
  end
  esp_rd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .spi_clk (spi_clk),
    .clr_n   (clr_n),
    .flush   (i_load),
    .wr      (rd_q),
    .wr_data (i_ram_data),
    .pop     (pop_eff),
    .rd_data (o_data),
    .vld     (o_data_vld),
    .count   (count)
  );
endmodule

// File: tb/tb_esp_rd_prefetch.sv
// tb_esp_rd_prefetch: randomized bench with a stream-level reference model of the prefetcher
module tb_esp_rd_prefetch;
  localparam int DEPTH = 4;
  localparam int ADDR_W = 14;
  localparam int CNT_W = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic spi_clk = 0, rst_n = 0, i_spi_cs_n = 0, i_load = 0, i_bank = 0, i_pop = 0;
  logic [ADDR_W-1:0] i_load_addr = '0;
  logic [7:0] i_ram_data = '0;
  logic [7:0] o_data;
  logic o_data_vld, o_ram_rd, o_underrun;
  logic [ADDR_W:0] o_ram_addr;
  logic [CNT_W-1:0] o_byte_cnt;
  int checks = 0, errors = 0;
  int cyc = 0, ld_cyc = 0, popped = 0, m_cnt = 0;
  bit stream = 0, m_unr = 0;
  logic [ADDR_W:0] base = '0;

  always #5 spi_clk = ~spi_clk;

  esp_rd_prefetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .spi_clk     (spi_clk),
    .rst_n       (rst_n),
    .i_spi_cs_n  (i_spi_cs_n),
    .i_load      (i_load),
    .i_load_addr (i_load_addr),
    .i_bank      (i_bank),
    .i_pop       (i_pop),
    .o_data      (o_data),
    .o_data_vld  (o_data_vld),
    .o_ram_rd    (o_ram_rd),
    .o_ram_addr  (o_ram_addr),
    .i_ram_data  (i_ram_data),
    .o_underrun  (o_underrun),
    .o_byte_cnt  (o_byte_cnt)
  );

  function automatic logic [7:0] ram_byte(input logic [ADDR_W:0] a);
    return a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  // synchronous-read RAM; garbage when not reading exposes unsquashed writes
  always @(posedge spi_clk) i_ram_data <= o_ram_rd ? ram_byte(o_ram_addr) : 8'($urandom);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // a stream delivers byte k into the FIFO at load edge + 2 + k
  function automatic bit avail();
    return stream && (cyc - ld_cyc >= 2 + popped);
  endfunction

  function automatic logic [ADDR_W:0] head_addr();
    return {base[ADDR_W], base[ADDR_W-1:0] + ADDR_W'(popped)};
  endfunction

  task automatic check_state();
    bit v;
    v = avail();
    check("vld", o_data_vld, v);
    check("data", o_data, v ? ram_byte(head_addr()) : 8'h00);
    check("cnt", o_byte_cnt, m_cnt);
    check("underrun", o_underrun, m_unr);
  endtask

  task automatic step(input bit ld, input logic [ADDR_W:0] a, input bit pop);
    bit v;
    v = avail();
    i_load = ld;
    i_bank = a[ADDR_W];
    i_load_addr = a[ADDR_W-1:0];
    i_pop = pop;
    @(posedge spi_clk);
    cyc++;
    if (ld) begin
      base = a;
      ld_cyc = cyc;
      popped = 0;
      m_cnt = 0;
      stream = 1;
    end else if (pop) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (v) popped++;
      else m_unr = 1;
    end
    @(negedge spi_clk);
    i_load = 0;
    i_pop = 0;
    check_state();
  endtask

  task automatic pops(input int n, input int gap);
    for (int p = 0; p < n; p++) begin
      step(0, '0, 1);
      repeat (gap - 1) step(0, '0, 0);
    end
  endtask

  initial begin
    logic [ADDR_W:0] a;
    int np;
    repeat (2) @(negedge spi_clk);
    check_state();
    check("rst_rd", o_ram_rd, 0);
    check("rst_addr", o_ram_addr, 0);
    rst_n = 1;
    step(1, 15'h0000, 0);
    check("ld_rd", o_ram_rd, 1);
    check("ld_addr", o_ram_addr, 15'h0000);
    step(0, '0, 0);
    step(0, '0, 0);
    pops(3, 2);
    check("cnt3", o_byte_cnt, 3);
    step(1, 15'h7FFE, 0);
    check("wrap0", o_ram_addr, 15'h7FFE);
    step(0, '0, 0);
    check("wrap1", o_ram_addr, 15'h7FFF);
    step(0, '0, 0);
    check("wrap2", o_ram_addr, 15'h4000);
    pops(4, 2);
    step(1, 15'h0050, 1);
    check("ldpop_cnt", o_byte_cnt, 0);
    check("ldpop_unr", o_underrun, 0);
    pops(2, 3);
    step(1, 15'h0100, 0);
    step(0, '0, 1);
    check("early_unr", o_underrun, 1);
    check("early_data", o_data, 8'h00);
    step(1, 15'h0200, 0);
    repeat (3) step(0, '0, 0);
    pops(5, 2);
    i_spi_cs_n = 1;
    #1;
    stream = 0;
    m_unr = 0;
    m_cnt = 0;
    popped = 0;
    check_state();
    check("cs_rd", o_ram_rd, 0);
    check("cs_addr", o_ram_addr, 0);
    @(negedge spi_clk);
    step(0, '0, 0);
    step(0, '0, 0);
    i_spi_cs_n = 0;
    step(0, '0, 1);
    step(1, 15'h1234, 0);
    repeat (2) step(0, '0, 0);
    pops(4, 2);
    step(1, 15'h3FF0, 0);
    pops(40, 2);
    check("cnt_sat", o_byte_cnt, CNT_MAX);
    for (int s = 0; s < 25; s++) begin
      a = 15'($urandom);
      if ($urandom_range(0, 3) == 0) a[ADDR_W-1:0] = 14'h3FFC + 14'($urandom_range(0, 3));
      step(1, a, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 5)) step(0, '0, 0);
      np = $urandom_range(2, 9);
      for (int p = 0; p < np; p++) begin
        step(0, '0, 1);
        repeat ($urandom_range(1, 3)) step(0, '0, 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
